// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and state encoding for the convolution window sequencer
package conv_pkg;

   localparam int SEL_W    = 4;
   localparam int NUM_TAPS = 9;
   localparam int IMG_N    = 4;
   localparam int FLT_N    = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

endpackage

// File: rtl/window_sel_gen.sv
// rtl/window_sel_gen.sv - maps a 2x2 output-window index to the nine 4-bit input-mux selects
module window_sel_gen
   import conv_pkg::*;
(
   input  logic [1:0]                win_i,
   output logic [SEL_W*NUM_TAPS-1:0] sel_o
);

   // win_i[1] is the window row offset, win_i[0] the column offset into the 4x4 image
   always_comb begin
      sel_o = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         sel_o[SEL_W*k +: SEL_W] = SEL_W'(IMG_N * (k / FLT_N + int'(win_i[1]))
                                          + (k % FLT_N) + int'(win_i[0]));
      end
   end

endmodule

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - walks the four 3x3 windows, drives mux selects and captures sums
module conv_window_sequencer
   import conv_pkg::*;
#(
   parameter int DW      = 8,
   parameter int MAC_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [DW-1:0] dp_out,
   output logic [35:0]   sel,
   output logic          init,
   output logic          preset,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] res11,
   output logic [DW-1:0] res12,
   output logic [DW-1:0] res21,
   output logic [DW-1:0] res22
);

   localparam logic [3:0] CNT_INIT = 4'(MAC_LAT - 1);

   state_e        state_q, state_d;
   logic [1:0]    win_q, win_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [DW-1:0] res_q [4];
   logic [DW-1:0] res_d [4];
   logic [35:0]   win_sel;

   window_sel_gen u_sel_gen (
      .win_i (win_q),
      .sel_o (win_sel)
   );

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d = ST_LOAD;
               win_d   = 2'd0;
            end
         end
         ST_LOAD: begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_CAPTURE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_CAPTURE: begin
            res_d[win_q] = dp_out;
            if (win_q == 2'd3) begin
               state_d = ST_DONE;
            end else begin
               win_d   = win_q + 2'd1;
               state_d = ST_LOAD;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // abort cancels everything including a capture in flight
      if (abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         win_d   = win_q;
         cnt_d   = cnt_q;
         res_d   = res_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         win_q   <= 2'd0;
         cnt_q   <= 4'd0;
         for (int i = 0; i < 4; i++) res_q[i] <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < 4; i++) res_q[i] <= res_d[i];
      end
   end

   always_comb begin
      sel    = (state_q == ST_IDLE) ? 36'd0 : win_sel;
      init   = (state_q == ST_LOAD);
      preset = (state_q == ST_IDLE);
      busy   = (state_q != ST_IDLE);
      done   = (state_q == ST_DONE);
   end

   assign res11 = res_q[0];
   assign res12 = res_q[1];
   assign res21 = res_q[2];
   assign res22 = res_q[3];

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - randomized and directed checks against a schedule-based model
module tb_conv_window_sequencer;

   localparam int ML = 2;
   localparam int WL = ML + 2;
   localparam int P  = 4 * WL + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, abort;
   logic [7:0]  dp_out;

   logic [35:0] sel;
   logic        init, preset, busy, done;
   logic [7:0]  r11, r12, r21, r22;

   logic [35:0] sel_a, sel_b;
   logic        init_a, preset_a, busy_a, done_a;
   logic        init_b, preset_b, busy_b, done_b;
   logic [7:0]  a11, a12, a21, a22, b11, b12, b21, b22;

   logic [1:0]  wsg_w;
   logic [35:0] wsg_sel;

   conv_window_sequencer #(.DW(8), .MAC_LAT(ML)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .dp_out(dp_out),
      .sel(sel), .init(init), .preset(preset), .busy(busy), .done(done),
      .res11(r11), .res12(r12), .res21(r21), .res22(r22));

   conv_window_sequencer #(.DW(8), .MAC_LAT(1)) dut_l1 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .dp_out(dp_out),
      .sel(sel_a), .init(init_a), .preset(preset_a), .busy(busy_a), .done(done_a),
      .res11(a11), .res12(a12), .res21(a21), .res22(a22));

   conv_window_sequencer #(.DW(8), .MAC_LAT(15)) dut_l15 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .dp_out(dp_out),
      .sel(sel_b), .init(init_b), .preset(preset_b), .busy(busy_b), .done(done_b),
      .res11(b11), .res12(b12), .res21(b21), .res22(b22));

   window_sel_gen u_wsg (.win_i(wsg_w), .sel_o(wsg_sel));

   int         cyc = 0;
   int         start_cyc = 0;
   bit         m_active = 1'b0;
   int         m_off = 0;
   logic [7:0] m_res [4];
   int         n_chk = 0;
   int         n_fail = 0;
   int         dp_mode = 0;
   bit         cmp_en = 1'b0;
   int         done_cnt = 0;
   int         main_rel = -1;
   int         l1_rel = -1;
   int         l15_rel = -1;
   int         init_q [$];

   function automatic logic [35:0] exp_sel(input int w);
      logic [35:0] r;
      int v;
      r = '0;
      for (int k = 0; k < 9; k++) begin
         v = 4 * (k / 3 + w / 2) + (k % 3 + w % 2);
         r[4*k +: 4] = 4'(v);
      end
      return r;
   endfunction

   function automatic int m_win();
      return (m_off == P) ? 3 : (m_off - 1) / WL;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      case (dp_mode)
         0:       dp_out = m_active ? 8'h10 + 8'(m_win()) : 8'h00;
         1:       dp_out = 8'($urandom);
         default: dp_out = 8'hFF;
      endcase
   endtask

   // pass modelled as an offset into a fixed schedule of P cycles
   always @(posedge clk) begin
      if (!rst) begin
         m_active = 1'b0;
         for (int i = 0; i < 4; i++) m_res[i] = 8'h00;
      end else if (m_active) begin
         if (abort) begin
            m_active = 1'b0;
         end else begin
            if (m_off < P && (m_off - 1) % WL == WL - 1) m_res[m_win()] = dp_out;
            if (m_off == P) m_active = 1'b0;
            else            m_off++;
         end
      end else if (start && !abort) begin
         m_active  = 1'b1;
         m_off     = 1;
         start_cyc = cyc;
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         if (m_active) begin
            chk("busy",   busy,   1'b1);
            chk("preset", preset, 1'b0);
            chk("init",   init,   (m_off < P) && ((m_off - 1) % WL == 0));
            chk("done",   done,   m_off == P);
            chk("sel",    sel,    exp_sel(m_win()));
         end else begin
            chk("busy",   busy,   1'b0);
            chk("preset", preset, 1'b1);
            chk("init",   init,   1'b0);
            chk("done",   done,   1'b0);
            chk("sel",    sel,    36'd0);
         end
         chk("res11", r11, m_res[0]);
         chk("res12", r12, m_res[1]);
         chk("res21", r21, m_res[2]);
         chk("res22", r22, m_res[3]);
         if (done) begin
            done_cnt++;
            main_rel = cyc - start_cyc;
         end
         if (init) init_q.push_back(cyc);
         if (done_a) l1_rel = cyc - start_cyc;
         if (done_b) l15_rel = cyc - start_cyc;
      end
   end

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0; dp_out = 8'h00; wsg_w = 2'd0;
      step();
      step();
      rst = 1'b1;
      cmp_en = 1'b1;

      repeat (10) begin
         step();
         chk("idle_busy", busy, 1'b0);
         chk("idle_preset", preset, 1'b1);
         chk("idle_sel", sel, 36'd0);
         chk("idle_done", done, 1'b0);
         chk("idle_res", {r11, r12, r21, r22}, 32'd0);
      end

      // latency sweep across three MAC_LAT values, sum of all ones
      dp_mode = 2;
      start = 1'b1; step(); start = 1'b0;
      repeat (75) step();
      chk("lat1_done_cycle", l1_rel, 13);
      chk("lat2_done_cycle", main_rel, 17);
      chk("lat15_done_cycle", l15_rel, 69);
      chk("wrap_res22", r22, 8'hFF);
      chk("wrap15_res22", b22, 8'hFF);

      // full pass with a stray start inside window 1 and another on the DONE cycle
      dp_mode = 0;
      init_q.delete();
      done_cnt = 0;
      main_rel = -1;
      start = 1'b1; step(); start = 1'b0;
      chk("w0_sel", sel, 36'hA98654210);
      chk("w0_init", init, 1'b1);
      repeat (5) step();
      start = 1'b1; step(); start = 1'b0;
      repeat (6) step();
      chk("w3_sel", sel, 36'hFEDBA9765);
      repeat (4) step();
      chk("done_at_17", done, 1'b1);
      start = 1'b1; step(); start = 1'b0;
      chk("start_in_done_ignored", busy, 1'b0);
      repeat (6) step();
      chk("pass_done_cycle", main_rel, 17);
      chk("pass_done_count", done_cnt, 1);
      chk("init_count", init_q.size(), 4);
      for (int i = 0; i + 1 < init_q.size(); i++) chk("init_spacing", init_q[i+1] - init_q[i], 4);
      chk("pass_res", {r11, r12, r21, r22}, 32'h10111213);

      // abort during window 2 wait
      done_cnt = 0;
      start = 1'b1; step(); start = 1'b0;
      repeat (9) step();
      abort = 1'b1; step(); abort = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_preset", preset, 1'b1);
      chk("abort_sel", sel, 36'd0);
      chk("abort_res", {r11, r12, r21, r22}, 32'h10111213);
      repeat (20) step();
      chk("abort_no_done", done_cnt, 0);

      // abort wins over start in idle
      start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
      chk("abort_start_idle", busy, 1'b0);

      // reset in window 1 capture, then a clean pass
      start = 1'b1; step(); start = 1'b0;
      repeat (7) step();
      rst = 1'b0; step(); rst = 1'b1;
      chk("rst_mid_res", {r11, r12, r21, r22}, 32'd0);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_preset", preset, 1'b1);
      main_rel = -1;
      start = 1'b1; step(); start = 1'b0;
      repeat (20) step();
      chk("rst_then_done_cycle", main_rel, 17);
      chk("rst_then_res", {r11, r12, r21, r22}, 32'h10111213);

      // random traffic
      dp_mode = 1;
      repeat (3000) begin
         step();
         start = ($urandom % 6) == 0;
         abort = ($urandom % 40) == 0;
         rst   = ($urandom % 250) != 0;
      end
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      step();

      for (int w = 0; w < 4; w++) begin
         wsg_w = 2'(w);
         #1;
         chk("wsg_sel", wsg_sel, exp_sel(w));
      end
      wsg_w = 2'd0;
      #1;
      chk("wsg_w0_literal", wsg_sel, 36'hA98654210);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
